// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared widths, state encoding and helpers for the Booth sequencer
package booth_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;
   localparam int MAG_W  = 15;
   localparam int BCD_W  = 20;
   localparam int DISP_W = 21;
   localparam int TIMEOUT_CYCLES_DEF = 1023;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_MUL_START = 3'd1;
   localparam logic [2:0] S_MUL_WAIT  = 3'd2;
   localparam logic [2:0] S_BCD_START = 3'd3;
   localparam logic [2:0] S_BCD_WAIT  = 3'd4;
   localparam logic [2:0] S_UPDATE    = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE      = S_IDLE,
      ST_MUL_START = S_MUL_START,
      ST_MUL_WAIT  = S_MUL_WAIT,
      ST_BCD_START = S_BCD_START,
      ST_BCD_WAIT  = S_BCD_WAIT,
      ST_UPDATE    = S_UPDATE
   } state_e;

   // Product range is -16256..16384, so the magnitude always fits 15 bits.
   function automatic logic [MAG_W-1:0] prod_mag(input logic [PROD_W-1:0] p);
      logic [PROD_W-1:0] n;
      n = p[PROD_W-1] ? (~p + PROD_W'(1)) : p;
      return n[MAG_W-1:0];
   endfunction

endpackage

// File: rtl/booth_sequencer_wait_timer.sv
// rtl/booth_sequencer_wait_timer.sv - wait-state cycle counter with expiry flag
module wait_timer
   import booth_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_count;

   // Expiry flags the LIMIT-th enabled cycle, so the caller leaves after exactly LIMIT cycles.
   assign o_expired = i_enable && (r_count == CW'(LIMIT - 1));

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear)
         r_count <= '0;
      else if (i_enable && !o_expired)
         r_count <= r_count + CW'(1);
   end

endmodule

// File: rtl/booth_sequencer.sv
// rtl/booth_sequencer.sv - sequences Booth multiply, BCD conversion and display update
module booth_sequencer
   import booth_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pb_pulse,
   input  logic [OP_W-1:0]   op_a,
   input  logic [OP_W-1:0]   op_b,
   output logic              mul_start,
   output logic [OP_W-1:0]   mul_a,
   output logic [OP_W-1:0]   mul_b,
   input  logic              mul_done,
   input  logic [PROD_W-1:0] mul_product,
   output logic              bcd_start,
   output logic [MAG_W-1:0]  bcd_bin,
   input  logic              bcd_done,
   input  logic [BCD_W-1:0]  bcd_digits,
   output logic [DISP_W-1:0] disp_code,
   output logic              busy,
   output logic              result_valid,
   output logic              err_timeout
);

   logic [2:0]        r_state;
   logic              r_mul_start;
   logic              r_bcd_start;
   logic              r_result_valid;
   logic              r_busy;
   logic              r_err;
   logic              r_sign;
   logic [OP_W-1:0]   r_mul_a;
   logic [OP_W-1:0]   r_mul_b;
   logic [MAG_W-1:0]  r_bcd_bin;
   logic [DISP_W-1:0] r_disp;
   logic              w_in_wait;
   logic              w_expired;

   assign w_in_wait = (r_state == S_MUL_WAIT) || (r_state == S_BCD_WAIT);

   wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_clear   (!w_in_wait),
      .i_enable  (w_in_wait),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_mul_start    <= 1'b0;
         r_bcd_start    <= 1'b0;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
         r_err          <= 1'b0;
         r_sign         <= 1'b0;
         r_mul_a        <= '0;
         r_mul_b        <= '0;
         r_bcd_bin      <= '0;
         r_disp         <= '0;
      end else begin
         r_mul_start    <= 1'b0;
         r_bcd_start    <= 1'b0;
         r_result_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (pb_pulse) begin
                  r_mul_a     <= op_a;
                  r_mul_b     <= op_b;
                  r_err       <= 1'b0;
                  r_mul_start <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_MUL_START;
               end
            end
            S_MUL_START: r_state <= S_MUL_WAIT;
            // A done strobe on the expiry cycle is still taken: done is tested first.
            S_MUL_WAIT: begin
               if (mul_done) begin
                  r_sign      <= mul_product[PROD_W-1] && (mul_product != '0);
                  r_bcd_bin   <= prod_mag(mul_product);
                  r_bcd_start <= 1'b1;
                  r_state     <= S_BCD_START;
               end else if (w_expired) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_BCD_START: r_state <= S_BCD_WAIT;
            S_BCD_WAIT: begin
               if (bcd_done) begin
                  r_disp         <= {r_sign, bcd_digits};
                  r_result_valid <= 1'b1;
                  r_state        <= S_UPDATE;
               end else if (w_expired) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_UPDATE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mul_start    = r_mul_start;
   assign mul_a        = r_mul_a;
   assign mul_b        = r_mul_b;
   assign bcd_start    = r_bcd_start;
   assign bcd_bin      = r_bcd_bin;
   assign disp_code    = r_disp;
   assign busy         = r_busy;
   assign result_valid = r_result_valid;
   assign err_timeout  = r_err;

endmodule

// File: tb/tb_booth_sequencer.sv
// tb/tb_booth_sequencer.sv - directed self-checking bench with timeline model for booth_sequencer
module tb_booth_sequencer;

   localparam int T   = 16;
   localparam int INF = 1 << 30;

   logic        clk = 1'b0;
   logic        reset, pb_pulse, mul_done, bcd_done;
   logic [7:0]  op_a, op_b, mul_a, mul_b;
   logic [15:0] mul_product;
   logic [19:0] bcd_digits;
   logic        mul_start, bcd_start, busy, result_valid, err_timeout;
   logic [14:0] bcd_bin;
   logic [20:0] disp_code;

   booth_sequencer #(.TIMEOUT_CYCLES(T)) dut (
      .clk          (clk),
      .reset        (reset),
      .pb_pulse     (pb_pulse),
      .op_a         (op_a),
      .op_b         (op_b),
      .mul_start    (mul_start),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_done     (mul_done),
      .mul_product  (mul_product),
      .bcd_start    (bcd_start),
      .bcd_bin      (bcd_bin),
      .bcd_done     (bcd_done),
      .bcd_digits   (bcd_digits),
      .disp_code    (disp_code),
      .busy         (busy),
      .result_valid (result_valid),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int ms_cnt = 0;
   int rv_cnt = 0;

   // Timeline model: event cycles of the current operation plus the values it must show.
   int          cyc;
   logic        m_valid;
   int          t_acc, t_md, t_bd, t_end;
   logic [7:0]  e_mula, e_mulb;
   logic [14:0] e_bin;
   logic        e_sign;
   logic [20:0] e_disp;
   logic        e_err;

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] d;
      int r;
      r = v;
      for (int i = 0; i < 5; i++) begin
         d[i*4 +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return d;
   endfunction

   function automatic logic busy_at(input int x);
      return (t_acc >= 0) && (x >= t_acc + 1) && (x < t_end);
   endfunction

   initial begin
      int pi, mag;
      m_valid = 1'b0;
      cyc = 0;
      t_acc = -1; t_md = -1; t_bd = -1; t_end = INF;
      e_mula = '0; e_mulb = '0; e_bin = '0; e_sign = 1'b0; e_disp = '0; e_err = 1'b0;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_valid = 1'b1;
            t_acc = -1; t_md = -1; t_bd = -1; t_end = INF;
            e_mula = '0; e_mulb = '0; e_bin = '0; e_sign = 1'b0; e_disp = '0; e_err = 1'b0;
         end else if (m_valid) begin
            if (!busy_at(cyc) && pb_pulse) begin
               t_acc = cyc; t_md = -1; t_bd = -1; t_end = INF;
               e_mula = op_a; e_mulb = op_b; e_err = 1'b0;
            end else if (t_acc >= 0 && t_end == INF) begin
               if (t_md < 0) begin
                  if (cyc >= t_acc + 2 && cyc <= t_acc + T + 1) begin
                     if (mul_done) begin
                        t_md = cyc;
                        pi = int'($signed(mul_product));
                        e_sign = (pi < 0);
                        mag = (pi < 0) ? -pi : pi;
                        e_bin = mag[14:0];
                     end else if (cyc == t_acc + T + 1) begin
                        e_err = 1'b1;
                        t_end = cyc + 1;
                     end
                  end
               end else if (t_bd < 0 && cyc >= t_md + 2 && cyc <= t_md + T + 1) begin
                  if (bcd_done) begin
                     t_bd = cyc;
                     e_disp = {e_sign, bcd_digits};
                     t_end = cyc + 2;
                  end else if (cyc == t_md + T + 1) begin
                     e_err = 1'b1;
                     t_end = cyc + 1;
                  end
               end
            end
         end
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare_step();
      int x;
      if (!m_valid) return;
      x = cyc;
      chk("busy",         32'(busy),         32'(busy_at(x)));
      chk("mul_start",    32'(mul_start),    32'(t_acc >= 0 && x == t_acc + 1));
      chk("bcd_start",    32'(bcd_start),    32'(t_md >= 0 && x == t_md + 1));
      chk("result_valid", 32'(result_valid), 32'(t_bd >= 0 && x == t_bd + 1));
      chk("mul_a",        32'(mul_a),        32'(e_mula));
      chk("mul_b",        32'(mul_b),        32'(e_mulb));
      chk("bcd_bin",      32'(bcd_bin),      32'(e_bin));
      chk("disp_code",    32'(disp_code),    32'(e_disp));
      chk("err_timeout",  32'(err_timeout),  32'(e_err));
      if (mul_start === 1'b1) ms_cnt++;
      if (result_valid === 1'b1) rv_cnt++;
   endtask

   task automatic tick();
      @(negedge clk);
      compare_step();
   endtask

   // md/bd: cycles from pb to mul_done and from mul_done to bcd_done (-1 = never).
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input int md, input int bd, input int xpb, input int rstk);
      int pa, pb, p, mag, total;
      pa = int'($signed(a));
      pb = int'($signed(b));
      p = pa * pb;
      mag = (p < 0) ? -p : p;
      total = (md < 0) ? T + 6 : md + ((bd < 0) ? T + 4 : bd + 4);
      ms_cnt = 0;
      rv_cnt = 0;
      for (int k = 0; k < total; k++) begin
         pb_pulse    = (k == 0) || (k == xpb);
         op_a        = (k == 0) ? a : 8'($urandom);
         op_b        = (k == 0) ? b : 8'($urandom);
         mul_done    = (k == md);
         mul_product = (k == md) ? 16'(p) : 16'($urandom);
         bcd_done    = (md >= 0) && (bd >= 0) && (k == md + bd);
         bcd_digits  = bcd_done ? to_bcd(mag) : 20'($urandom);
         reset       = (k == rstk);
         tick();
      end
      pb_pulse = 1'b0; mul_done = 1'b0; bcd_done = 1'b0; reset = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      reset = 1'b1; pb_pulse = 1'b0; mul_done = 1'b0; bcd_done = 1'b0;
      op_a = '0; op_b = '0; mul_product = '0; bcd_digits = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_disp", 32'(disp_code), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);

      run_op(8'd3, 8'd5, 8, 3, -1, -1);
      chk("lit_disp_3x5", 32'(disp_code), 32'h000015);
      chk("lit_bin_3x5", 32'(bcd_bin), 32'd15);
      chk("lit_rv_3x5", 32'(rv_cnt), 32'd1);

      run_op(8'hFD, 8'd5, 4, 2, -1, -1);
      chk("lit_disp_m3x5", 32'(disp_code), 32'h100015);
      chk("lit_bin_m3x5", 32'(bcd_bin), 32'd15);

      run_op(8'd0, 8'hF9, 3, 3, -1, -1);
      chk("lit_disp_zero", 32'(disp_code), 32'h000000);

      run_op(8'h80, 8'h80, 5, 6, -1, -1);
      chk("lit_disp_max", 32'(disp_code), 32'h016384);
      chk("lit_bin_max", 32'(bcd_bin), 32'd16384);

      run_op(8'd9, 8'd9, -1, -1, -1, -1);
      chk("lit_to_err", 32'(err_timeout), 32'd1);
      chk("lit_to_busy", 32'(busy), 32'd0);
      chk("lit_to_disp", 32'(disp_code), 32'h016384);
      chk("lit_to_rv", 32'(rv_cnt), 32'd0);

      for (int k = 0; k < 3; k++) begin
         mul_done = 1'b1; bcd_done = 1'b1;
         mul_product = 16'($urandom); bcd_digits = 20'($urandom);
         tick();
      end
      mul_done = 1'b0; bcd_done = 1'b0;
      tick();

      run_op(8'd7, 8'hF7, T + 1, 2, -1, -1);
      chk("lit_edge_disp", 32'(disp_code), 32'h100063);
      chk("lit_edge_err", 32'(err_timeout), 32'd0);

      run_op(8'd12, 8'd11, 6, 3, 3, -1);
      chk("lit_dup_ms", 32'(ms_cnt), 32'd1);
      chk("lit_dup_rv", 32'(rv_cnt), 32'd1);
      chk("lit_dup_disp", 32'(disp_code), 32'h000132);
      chk("lit_dup_mula", 32'(mul_a), 32'd12);

      run_op(8'd2, 8'd2, 3, -1, -1, -1);
      chk("lit_bto_err", 32'(err_timeout), 32'd1);
      chk("lit_bto_disp", 32'(disp_code), 32'h000132);

      run_op(8'd4, 8'd6, 4, 4, -1, 7);
      chk("lit_rst_disp", 32'(disp_code), 32'h0);
      chk("lit_rst_rv", 32'(rv_cnt), 32'd0);
      chk("lit_rst_busy", 32'(busy), 32'd0);
      chk("lit_rst_err", 32'(err_timeout), 32'd0);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
